// File: rtl/fetch_unit.sv
// fetch_unit: PC register plus one-outstanding-read instruction fetch FSM.
// Optional WAIT-state timeout (NOP delivery + sticky fault) under FETCH_TIMEOUT_EN.
module fetch_unit #(
   parameter int                ADDR_W         = 8,
   parameter int                INSTR_W        = 16,
   parameter logic [ADDR_W-1:0] RESET_PC       = '0,
   parameter int                TIMEOUT_CYCLES = 15
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_run_en,
   output logic               o_mem_req,
   output logic [ADDR_W-1:0]  o_mem_addr,
   input  logic [INSTR_W-1:0] i_mem_rdata,
   input  logic               i_mem_valid,
   output logic               o_instr_valid,
   output logic [INSTR_W-1:0] o_instruction,
   output logic [ADDR_W-1:0]  o_address,
   input  logic               i_instr_ready,
   input  logic [ADDR_W-1:0]  i_new_pc,
   output logic [15:0]        o_fetch_count,
   output logic               o_fetch_fault
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_HOLD
   } state_t;

   state_t            r_state;
   logic [ADDR_W-1:0] r_pc;
   logic              w_timeout;

`ifdef FETCH_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic [TW-1:0] r_to_cnt;
   logic          r_fault;

   assign w_timeout     = (r_to_cnt == TW'(TIMEOUT_CYCLES - 1));
   assign o_fetch_fault = r_fault;

   // Counter restarts in REQ so every WAIT visit gets the full budget.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_to_cnt <= '0;
         r_fault  <= 1'b0;
      end else if (r_state == S_REQ) begin
         r_to_cnt <= '0;
      end else if (r_state == S_WAIT && !i_mem_valid) begin
         if (w_timeout) r_fault  <= 1'b1;
         else           r_to_cnt <= r_to_cnt + TW'(1);
      end
   end
`else
   logic w_unused_to;

   assign w_timeout     = 1'b0;
   assign w_unused_to   = ^TIMEOUT_CYCLES;
   assign o_fetch_fault = 1'b0;
`endif

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state       <= S_IDLE;
         r_pc          <= RESET_PC;
         o_mem_req     <= 1'b0;
         o_mem_addr    <= '0;
         o_instr_valid <= 1'b0;
         o_instruction <= '0;
         o_address     <= '0;
         o_fetch_count <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_run_en) begin
                  o_mem_req  <= 1'b1;
                  o_mem_addr <= r_pc;
                  r_state    <= S_REQ;
               end
            end
            S_REQ: begin
               o_mem_req <= 1'b0;
               r_state   <= S_WAIT;
            end
            S_WAIT: begin
               if (i_mem_valid) begin
                  o_instruction <= i_mem_rdata;
                  o_address     <= r_pc;
                  o_instr_valid <= 1'b1;
                  r_state       <= S_HOLD;
               end else if (w_timeout) begin
                  o_instruction <= '0;
                  o_address     <= r_pc;
                  o_instr_valid <= 1'b1;
                  r_state       <= S_HOLD;
               end
            end
            S_HOLD: begin
               if (i_instr_ready) begin
                  r_pc          <= i_new_pc;
                  o_instr_valid <= 1'b0;
                  o_fetch_count <= o_fetch_count + 16'd1;
                  r_state       <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized fetch traffic against a queue-based fetch model.
// A monitor pops expected fetches and compares whenever the DUT presents them.
module tb_fetch_unit;

   localparam int TO = 15;

   typedef struct {
      logic [7:0]  a;
      logic [15:0] d;
   } rsp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        run_en = 1'b0;
   logic        mem_req;
   logic [7:0]  mem_addr;
   logic [15:0] mem_rdata = '0;
   logic        mem_valid = 1'b0;
   logic        instr_valid;
   logic [15:0] instruction;
   logic [7:0]  address;
   logic        instr_ready = 1'b0;
   logic [7:0]  new_pc = '0;
   logic [15:0] fetch_count;
   logic        fetch_fault;

   always #5 clk = ~clk;

   fetch_unit dut (
      .i_clk         (clk),
      .i_reset       (rst),
      .i_run_en      (run_en),
      .o_mem_req     (mem_req),
      .o_mem_addr    (mem_addr),
      .i_mem_rdata   (mem_rdata),
      .i_mem_valid   (mem_valid),
      .o_instr_valid (instr_valid),
      .o_instruction (instruction),
      .o_address     (address),
      .i_instr_ready (instr_ready),
      .i_new_pc      (new_pc),
      .o_fetch_count (fetch_count),
      .o_fetch_fault (fetch_fault)
   );

   logic [15:0] mem [256];
   int   tests = 0;
   int   fails = 0;
   bit   hold = 1'b1;
   bit   mute = 1'b0;
   bit   slow = 1'b0;

   // reference model state
   rsp_t        rsp_q[$];
   logic [7:0]  m_pc = '0;
   logic [15:0] m_cnt = '0;
   logic        m_fault = 1'b0;
   logic        exp_valid = 1'b0;
   bit          pending = 1'b0;
   bit          after_rst = 1'b0;
   int          wcnt = 0;

   task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
      end
   endtask

   // input driver
   initial begin
      forever begin
         @(posedge clk);
         #2;
         run_en      = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
         instr_ready = hold ? 1'b0 : ($urandom_range(0, 2) == 0);
         case ($urandom_range(0, 3))
            0:       new_pc = 8'hFF;
            1:       new_pc = 8'h00;
            default: new_pc = 8'($urandom);
         endcase
      end
   end

   // memory responder, with spurious strobes outside WAIT
   initial begin
      logic [7:0] a;
      int         lat;
      forever begin
         @(negedge clk);
         if (mem_req && !mute) begin
            a   = mem_addr;
            lat = slow ? 4 : $urandom_range(1, 3);
            repeat (lat) @(posedge clk);
            #2;
            mem_valid = 1'b1;
            mem_rdata = mem[a];
            @(posedge clk);
            #2;
            mem_valid = 1'b0;
            mem_rdata = 16'($urandom);
         end else if (!mem_req && (instr_valid || (!run_en && !pending))
                      && $urandom_range(0, 5) == 0) begin
            @(posedge clk);
            #2;
            mem_valid = 1'b1;
            mem_rdata = 16'($urandom);
            @(posedge clk);
            #2;
            mem_valid = 1'b0;
         end
      end
   end

   // monitor + scoreboard
   always @(negedge clk) begin
      rsp_t e;
      bit   acc;
      if (rst) begin
         rsp_q.delete();
         m_pc      = 8'h00;
         m_cnt     = '0;
         m_fault   = 1'b0;
         exp_valid = 1'b0;
         pending   = 1'b0;
         after_rst = 1'b1;
      end else begin
         if (after_rst) begin
            chk("rst_mem_req", 32'(mem_req), 0);
            chk("rst_mem_addr", 32'(mem_addr), 0);
            chk("rst_instruction", 32'(instruction), 0);
            chk("rst_address", 32'(address), 0);
            after_rst = 1'b0;
         end
         chk("fetch_count", 32'(fetch_count), 32'(m_cnt));
         chk("fetch_fault", 32'(fetch_fault), 32'(m_fault));
         chk("instr_valid", 32'(instr_valid), 32'(exp_valid));
         if (exp_valid) begin
            chk("rsp_q_depth", 32'(rsp_q.size()), 1);
            if (rsp_q.size() > 0) begin
               chk("instruction", 32'(instruction), 32'(rsp_q[0].d));
               chk("address", 32'(address), 32'(rsp_q[0].a));
            end
         end
         if (mem_req) begin
            chk("mem_addr", 32'(mem_addr), 32'(m_pc));
            chk("req_while_busy", 32'(rsp_q.size()), 0);
         end
         acc = exp_valid && instr_ready;
         exp_valid = exp_valid && !instr_ready;
         if (pending) begin
            if (mem_valid) begin
               pending   = 1'b0;
               exp_valid = 1'b1;
            end else begin
               wcnt++;
`ifdef FETCH_TIMEOUT_EN
               if (wcnt == TO) begin
                  pending     = 1'b0;
                  exp_valid   = 1'b1;
                  rsp_q[0].d  = 16'h0000;
                  m_fault     = 1'b1;
               end
`endif
            end
         end
         if (mem_req) begin
            e.a = m_pc;
            e.d = mem[m_pc];
            rsp_q.push_back(e);
            pending = 1'b1;
            wcnt    = 0;
         end
         if (acc) begin
            void'(rsp_q.pop_front());
            m_pc  = new_pc;
            m_cnt = m_cnt + 16'd1;
         end
      end
   end

   initial begin
      bit seen;
      for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
      mem[0] = 16'h0052;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #2;
      rst  = 1'b0;
      hold = 1'b0;
      repeat (2000) @(posedge clk);

`ifdef FETCH_TIMEOUT_EN
      mute = 1'b1;
      repeat (120) @(posedge clk);
      mute = 1'b0;
      repeat (200) @(posedge clk);
`endif

      // reset while a fetch sits in WAIT; late reply must be ignored
      slow = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < 400 && !seen; k++) begin
         @(negedge clk);
         seen = mem_req;
      end
      chk("req_seen", 32'(seen), 1);
      hold = 1'b1;
      @(posedge clk);
      #2;
      rst = 1'b1;
      @(posedge clk);
      #2;
      rst = 1'b0;
      repeat (8) @(posedge clk);
      slow = 1'b0;
      hold = 1'b0;
      repeat (1500) @(posedge clk);

      hold = 1'b1;
      repeat (20) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
